// File: rtl/mux_scan_ctrl.sv
// Round-robin sampler for an 8:1 mux: steps sel over the enabled channels, waits SETTLE cycles, assembles a word.
// Optional continuous mode: define MUX_SCAN_CONT_EN to rescan with the latched mask after every transfer.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] chan_mask,
  input  logic       mux_o,
  output logic [2:0] sel,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0] state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] shadow_q, shadow_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;

  // Returns {found, channel}: lowest enabled channel strictly above 'from' (from=-1 gives the lowest overall).
  function automatic logic [3:0] next_chan(input logic [7:0] m, input int from);
    logic [3:0] r;
    r = 4'd0;
    for (int k = 7; k >= 0; k--) begin
      if (m[k] && (k > from)) r = {1'b1, 3'(k)};
    end
    return r;
  endfunction

  logic [3:0] first_new, first_old, higher;

  always_comb begin
    first_new = next_chan(chan_mask, -1);
    first_old = next_chan(mask_q, -1);
    higher    = next_chan(mask_q, int'(sel_q));

    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    valid_d  = valid_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d   = chan_mask;
          shadow_d = 8'h00;
          if (first_new[3]) begin
            sel_d   = first_new[2:0];
            cnt_d   = 4'(SETTLE);
            state_d = S_SETTLE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_SETTLE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          shadow_d[sel_q] = mux_o;
          if (higher[3]) begin
            sel_d = higher[2:0];
            cnt_d = 4'(SETTLE);
          end else begin
            data_d  = shadow_d;
            valid_d = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        // An empty mask arrives here with valid low; publish the cleared shadow one edge later.
        if (!valid_q) begin
          data_d  = shadow_q;
          valid_d = 1'b1;
        end else if (ready) begin
          valid_d = 1'b0;
`ifdef MUX_SCAN_CONT_EN
          shadow_d = 8'h00;
          if (first_old[3]) begin
            sel_d   = first_old[2:0];
            cnt_d   = 4'(SETTLE);
            state_d = S_SETTLE;
          end else begin
            state_d = S_DONE;
          end
`else
          state_d = S_IDLE;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sel_q    <= 3'd0;
      cnt_q    <= 4'd0;
      mask_q   <= 8'h00;
      shadow_q <= 8'h00;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  assign sel   = sel_q;
  assign data  = data_q;
  assign valid = valid_q;
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed self-checking bench for mux_scan_ctrl; the 8:1 mux is modelled as i_model[sel].
module tb_mux_scan_ctrl;

`ifdef MUX_SCAN_CONT_EN
  localparam int unsigned ST = 0;
`else
  localparam int unsigned ST = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] chan_mask = 8'h00;
  logic       mux_o;
  logic [2:0] sel;
  logic [7:0] data;
  logic       valid;
  logic       ready = 1'b0;
  logic       busy;
  logic [7:0] i_model = 8'h00;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;
  assign mux_o = i_model[sel];

  mux_scan_ctrl #(.SETTLE(ST)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .chan_mask(chan_mask),
    .mux_o(mux_o), .sel(sel), .data(data), .valid(valid),
    .ready(ready), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] m);
    chan_mask = m;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; ready = 1'b0; chan_mask = 8'h00;
    repeat (3) step();
    checks++; if (sel !== 3'd0)  begin errors++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    step();
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
    $display("reset done");
  endtask

  task automatic test_full_backpressure();
    logic [2:0] exp_sel;
    ready = 1'b0; i_model = 8'hA5;
    do_start(8'hFF);
    for (int m = 0; m < 16; m++) begin
      if (m > 0) step();
      exp_sel = 3'(m / 2);
      checks++; if (sel !== exp_sel) begin errors++; $display("FAIL full_sel m=%0d got=%0d exp=%0d", m, sel, exp_sel); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL full_valid_early m=%0d got=%b exp=0", m, valid); end
      checks++; if (busy !== 1'b1)  begin errors++; $display("FAIL full_busy m=%0d got=%b exp=1", m, busy); end
      // A start with a different mask mid-scan must be ignored.
      if (m == 5) begin start = 1'b1; chan_mask = 8'h01; end
      if (m == 6) start = 1'b0;
    end
    step();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL full_valid got=%b exp=1", valid); end
    checks++; if (data !== 8'hA5) begin errors++; $display("FAIL full_data got=%h exp=a5", data); end
    checks++; if (sel !== 3'd7)   begin errors++; $display("FAIL full_sel_done got=%0d exp=7", sel); end
    $display("scan mask=ff data=%h", data);
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 3) start = 1'b1;
      if (c == 4) start = 1'b0;
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL bp_valid c=%0d got=%b exp=1", c, valid); end
      checks++; if (data !== 8'hA5) begin errors++; $display("FAIL bp_data c=%0d got=%h exp=a5", c, data); end
      checks++; if (sel !== 3'd7)   begin errors++; $display("FAIL bp_sel c=%0d got=%0d exp=7", c, sel); end
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL bp_xfer_valid got=%b exp=0", valid); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL bp_xfer_busy got=%b exp=0", busy); end
    step();
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL bp_idle_busy got=%b exp=0", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL bp_single_xfer got=%b exp=0", valid); end
  endtask

  task automatic test_reset_mid_scan();
    ready = 1'b0; i_model = 8'h5A;
    do_start(8'hFF);
    repeat (6) step();
    checks++; if (sel !== 3'd3) begin errors++; $display("FAIL mid_sel_pre got=%0d exp=3", sel); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (sel !== 3'd0)   begin errors++; $display("FAIL mid_rst_sel got=%0d exp=0", sel); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL mid_rst_data got=%h exp=00", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got=%b exp=0", valid); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    #2 rst_n = 1'b1;
    i_model = 8'h3C;
    step();
    do_start(8'hFF);
    repeat (15) step();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mid_new_early got=%b exp=0", valid); end
    step();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL mid_new_valid got=%b exp=1", valid); end
    checks++; if (data !== 8'h3C) begin errors++; $display("FAIL mid_new_data got=%h exp=3c", data); end
    $display("scan after reset mask=ff data=%h", data);
    ready = 1'b1;
    step();
    ready = 1'b0;
  endtask

  task automatic test_sparse();
    logic [2:0] exp_sel [4];
    exp_sel[0] = 3'd1; exp_sel[1] = 3'd1; exp_sel[2] = 3'd4; exp_sel[3] = 3'd4;
    ready = 1'b0; i_model = 8'hFF;
    do_start(8'h12);
    for (int m = 0; m < 4; m++) begin
      if (m > 0) step();
      checks++; if (sel !== exp_sel[m]) begin errors++; $display("FAIL sparse_sel m=%0d got=%0d exp=%0d", m, sel, exp_sel[m]); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL sparse_valid_early m=%0d got=%b exp=0", m, valid); end
    end
    step();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL sparse_valid got=%b exp=1", valid); end
    checks++; if (data !== 8'h12) begin errors++; $display("FAIL sparse_data got=%h exp=12", data); end
    $display("scan mask=12 data=%h", data);
    ready = 1'b1;
    step();
    ready = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sparse_xfer_busy got=%b exp=0", busy); end
  endtask

  task automatic test_zero_mask();
    ready = 1'b1; i_model = 8'hFF;
    do_start(8'h00);
    checks++; if (busy !== 1'b1)  begin errors++; $display("FAIL zero_busy got=%b exp=1", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL zero_valid_e0 got=%b exp=0", valid); end
    step();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL zero_valid got=%b exp=1", valid); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL zero_data got=%h exp=00", data); end
    $display("scan mask=00 data=%h", data);
    step();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL zero_xfer_valid got=%b exp=0", valid); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL zero_xfer_busy got=%b exp=0", busy); end
    ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    ready = 1'b1; i_model = 8'h01;
    chan_mask = 8'h01;
    start = 1'b1;
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy0 got=%b exp=1", busy); end
    repeat (2) step();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL b2b_valid1 got=%b exp=1", valid); end
    checks++; if (data !== 8'h01) begin errors++; $display("FAIL b2b_data1 got=%h exp=01", data); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_gap_busy got=%b exp=0", busy); end
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart_busy got=%b exp=1", busy); end
    repeat (2) step();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL b2b_valid2 got=%b exp=1", valid); end
    $display("back-to-back second word data=%h", data);
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_end_busy got=%b exp=0", busy); end
    ready = 1'b0;
  endtask

  task automatic test_continuous();
    logic [7:0] words [3];
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hC3;
    ready = 1'b1; i_model = words[0];
    do_start(8'hFF);
    chan_mask = 8'h01;
    for (int w = 0; w < 3; w++) begin
      for (int m = 0; m < 8; m++) begin
        if (m > 0) step();
        checks++; if (sel !== 3'(m)) begin errors++; $display("FAIL cont_sel w=%0d m=%0d got=%0d exp=%0d", w, m, sel, m); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cont_busy w=%0d m=%0d got=%b exp=1", w, m, busy); end
      end
      step();
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL cont_valid w=%0d got=%b exp=1", w, valid); end
      checks++; if (data !== words[w]) begin errors++; $display("FAIL cont_data w=%0d got=%h exp=%h", w, data, words[w]); end
      $display("continuous word %0d data=%h", w, data);
      if (w < 2) i_model = words[w + 1];
      step();
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL cont_xfer w=%0d got=%b exp=0", w, valid); end
    end
    rst_n = 1'b0;
    ready = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
`ifdef MUX_SCAN_CONT_EN
    test_continuous();
`else
    test_full_backpressure();
    test_reset_mid_scan();
    test_sparse();
    test_zero_mask();
    test_back_to_back();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
